// File: rtl/jk_counter_ctrl.sv
// Sequencing controller for a bank of WIDTH JK flip-flops wired as a
// programmable up/down counter with clear/load, pause, abort and done pulse.
module jk_counter_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             enable,
    input  logic             start,
    input  logic             stop,
    input  logic             up,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] term,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             ff_enable,
    output logic             ff_clr,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       r_state;
    logic             r_up;
    logic [WIDTH-1:0] r_load_val;
    logic [WIDTH-1:0] r_term;

    logic [2:0]       w_next;
    logic             w_latch;
    logic [WIDTH-1:0] w_t;

    // State and latched-field register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state    <= S_IDLE;
            r_up       <= 1'b0;
            r_load_val <= '0;
            r_term     <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_up       <= up;
                r_load_val <= load_val;
                r_term     <= term;
            end
        end
    end

    // Toggle vector: bit i flips when every lower bit is 1 (up) or 0 (down)
    always_comb begin
        logic acc;
        acc    = 1'b1;
        w_t    = '0;
        w_t[0] = 1'b1;
        for (int i = 1; i < int'(WIDTH); i++) begin
            acc    = acc & (r_up ? q_fb[i-1] : ~q_fb[i-1]);
            w_t[i] = acc;
        end
    end

    // Next-state and flop-bank drive decode; reset forces every output low
    always_comb begin
        w_next    = r_state;
        w_latch   = 1'b0;
        j         = '0;
        k         = '0;
        ff_enable = 1'b0;
        ff_clr    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start && enable) begin
                    w_latch = 1'b1;
                    w_next  = load_en ? S_LOAD : S_CLEAR;
                end
            end
            S_CLEAR: begin
                busy      = 1'b1;
                ff_enable = 1'b1;
                ff_clr    = 1'b1;
                w_next    = S_RUN;
            end
            S_LOAD: begin
                busy      = 1'b1;
                ff_enable = 1'b1;
                j         = r_load_val;
                k         = ~r_load_val;
                w_next    = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (stop) begin
                    w_next = S_IDLE;
                end else if (!enable) begin
                    w_next = S_RUN;
                end else if (q_fb == r_term) begin
                    w_next = S_DONE;
                end else begin
                    ff_enable = 1'b1;
                    j         = w_t;
                    k         = w_t;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        if (!clr) begin
            j         = '0;
            k         = '0;
            ff_enable = 1'b0;
            ff_clr    = 1'b0;
            busy      = 1'b0;
            done      = 1'b0;
        end
    end

endmodule

// File: tb/tb_jk_counter_ctrl.sv
// Bench for jk_counter_ctrl: emulates the JK flop bank and checks every cycle
// against an arithmetic reference model of the counter sequence.
module tb_jk_counter_ctrl;

    localparam int unsigned W    = 4;
    localparam int          MASK = (1 << W) - 1;

    localparam int M_IDLE  = 0;
    localparam int M_CLEAR = 1;
    localparam int M_LOAD  = 2;
    localparam int M_RUN   = 3;
    localparam int M_DONE  = 4;

    logic         clk = 1'b0;
    logic         clr, enable, start, stop, up, load_en;
    logic [W-1:0] load_val, term;
    logic [W-1:0] q_fb;
    logic [W-1:0] j, k;
    logic         ff_enable, ff_clr, busy, done;

    logic [W-1:0] bank_q = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_busy   = 0;
    int n_done   = 0;

    int m_st    = M_IDLE;
    int m_up    = 0;
    int m_lv    = 0;
    int m_term  = 0;
    int m_count = 0;

    always #5 clk = ~clk;

    jk_counter_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .clr(clr), .enable(enable), .start(start), .stop(stop),
        .up(up), .load_en(load_en), .load_val(load_val), .term(term),
        .q_fb(q_fb), .j(j), .k(k), .ff_enable(ff_enable), .ff_clr(ff_clr),
        .busy(busy), .done(done)
    );

    // JK flop bank: clear wins, otherwise J sets, K resets, J=K toggles
    always @(posedge clk) begin
        if (ff_clr)
            bank_q <= '0;
        else if (ff_enable)
            bank_q <= (j & ~bank_q) | (~k & bank_q);
    end
    assign q_fb = bank_q;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare mid-cycle, then advance the model on the edge
    task automatic step(input int n);
        for (int c = 0; c < n; c++) begin
            logic [W-1:0] ej, ek;
            logic         een, eclr, ebusy, edone;
            int           nxt;
            @(negedge clk);
            ej = '0; ek = '0; een = 1'b0; eclr = 1'b0; ebusy = 1'b0; edone = 1'b0;
            if (clr) begin
                case (m_st)
                    M_CLEAR: begin ebusy = 1'b1; een = 1'b1; eclr = 1'b1; end
                    M_LOAD: begin
                        ebusy = 1'b1; een = 1'b1;
                        ej = W'(m_lv); ek = ~W'(m_lv);
                    end
                    M_RUN: begin
                        ebusy = 1'b1;
                        if (!stop && enable && m_count != m_term) begin
                            nxt = m_up != 0 ? (m_count + 1) & MASK : (m_count - 1) & MASK;
                            een = 1'b1;
                            ej  = W'(nxt ^ m_count);
                            ek  = ej;
                        end
                    end
                    M_DONE: edone = 1'b1;
                    default: ;
                endcase
            end
            chk("q_fb", q_fb, W'(m_count));
            chk("j", j, ej);
            chk("k", k, ek);
            chk("ff_enable", W'(ff_enable), W'(een));
            chk("ff_clr", W'(ff_clr), W'(eclr));
            chk("busy", W'(busy), W'(ebusy));
            chk("done", W'(done), W'(edone));
            if (busy) n_busy++;
            if (done) n_done++;

            @(posedge clk);
            if (!clr) begin
                m_st = M_IDLE; m_up = 0; m_lv = 0; m_term = 0;
            end else begin
                case (m_st)
                    M_IDLE: if (start && enable) begin
                        m_up = int'(up); m_lv = int'(load_val); m_term = int'(term);
                        m_st = load_en ? M_LOAD : M_CLEAR;
                    end
                    M_CLEAR: begin m_count = 0; m_st = M_RUN; end
                    M_LOAD:  begin m_count = m_lv; m_st = M_RUN; end
                    M_RUN: begin
                        if (stop)                  m_st = M_IDLE;
                        else if (!enable)          m_st = M_RUN;
                        else if (m_count == m_term) m_st = M_DONE;
                        else m_count = m_up != 0 ? (m_count + 1) & MASK : (m_count - 1) & MASK;
                    end
                    default: m_st = M_IDLE;
                endcase
            end
            #1;
        end
    endtask

    task automatic kick(input logic u, input logic le, input logic [W-1:0] lv, input logic [W-1:0] tm);
        up = u; load_en = le; load_val = lv; term = tm;
        start = 1'b1;
        step(1);
        start = 1'b0;
        n_busy = 0; n_done = 0;
    endtask

    initial begin
        clr = 1'b0; enable = 1'b1; start = 1'b1; stop = 1'b0;
        up = 1'b1; load_en = 1'b0; load_val = '0; term = '0;

        // Reset held with start asserted, then idle after release
        step(2);
        clr = 1'b1; start = 1'b0;
        step(3);

        // Up count from clear to 5
        kick(1'b1, 1'b0, 4'd0, 4'd5);
        step(9);
        chk("upclr_busy_cycles", W'(n_busy), 4'd7);
        chk("upclr_done_pulses", W'(n_done), 4'd1);

        // Load 12, count down to 9; then change inputs afterwards (no effect)
        kick(1'b0, 1'b1, 4'd12, 4'd9);
        up = 1'b1; term = 4'd3; load_val = 4'd0;
        step(7);
        chk("down_done_pulses", W'(n_done), 4'd1);

        // Wrap-around 14,15,0,1
        kick(1'b1, 1'b1, 4'd14, 4'd1);
        step(7);
        chk("wrap_done_pulses", W'(n_done), 4'd1);

        // Preload equals terminal: zero counts
        kick(1'b1, 1'b1, 4'd7, 4'd7);
        step(4);
        chk("equal_done_pulses", W'(n_done), 4'd1);

        // Pause at 3, ignored mid-run start, abort at 6
        kick(1'b1, 1'b0, 4'd0, 4'd10);
        step(4);
        enable = 1'b0;
        step(3);
        enable = 1'b1;
        start = 1'b1;
        step(3);
        start = 1'b0; stop = 1'b1;
        step(1);
        stop = 1'b0;
        step(3);
        chk("abort_done_pulses", W'(n_done), 4'd0);

        // Reset mid-run at 2, then fresh count to 2
        kick(1'b1, 1'b0, 4'd0, 4'd9);
        step(3);
        clr = 1'b0;
        step(1);
        clr = 1'b1;
        step(1);
        kick(1'b1, 1'b0, 4'd0, 4'd2);
        step(6);
        chk("rst_rerun_done_pulses", W'(n_done), 4'd1);

        // Randomized traffic
        for (int r = 0; r < 1500; r++) begin
            clr      = ($urandom % 64) != 0;
            enable   = ($urandom % 8) != 0;
            start    = ($urandom % 4) == 0;
            stop     = ($urandom % 32) == 0;
            up       = 1'($urandom);
            load_en  = 1'($urandom);
            load_val = W'($urandom);
            term     = W'($urandom);
            step(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
